// File: rtl/motor_dose_timer.sv
// Dose timer for the three paint dispensing motors (R, Y, B).
// Runs the requested motor for dose*TICKS_PER_UNIT cycles, waits a settle
// time with the motor off, then raises the channel's done flag until the
// sequencer moves its request on.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no motor running; accepts dose loads and new requests
// RUN    | motor ch driven; prescaler/units counting the dose down
// SETTLE | motor off, drip/settle down-counter running
// DONE   | flags[ch] held until the request changes
module motor_dose_timer #(
  parameter int DOSE_W         = 8,
  parameter int TICKS_PER_UNIT = 1000,
  parameter int SETTLE_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DOSE_W-1:0] dose_r,
  input  logic [DOSE_W-1:0] dose_y,
  input  logic [DOSE_W-1:0] dose_b,
  input  logic [2:0]        motor_req,
  output logic [2:0]        motor_on,
  output logic [2:0]        flags,
  output logic              busy,
  output logic              err
);

  localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [PW-1:0]     PRESC_LAST  = PW'(TICKS_PER_UNIT - 1);
  localparam logic [SW-1:0]     SETTLE_LOAD = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0]     SETTLE_ONE  = SW'(1);
  localparam logic [DOSE_W-1:0] UNITS_ONE   = DOSE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q;
  logic [DOSE_W-1:0] dose_r_q, dose_y_q, dose_b_q;
  logic [2:0]        ch_q;
  logic [DOSE_W-1:0] units_q;
  logic [PW-1:0]     presc_q;
  logic [SW-1:0]     settle_q;
  logic [2:0]        motor_on_q;
  logic [2:0]        flags_q;
  logic              busy_q;
  logic              err_q;

  logic              req_onehot;
  logic              req_multi;
  logic [DOSE_W-1:0] units_start_d;

  // Classify the request and pick its dose; a load in the same cycle wins
  // over the stored dose so the sequencer can load and start together.
  always_comb begin
    req_onehot    = (motor_req != 3'b000) &&
                    ((motor_req & (motor_req - 3'd1)) == 3'b000);
    req_multi     = (motor_req != 3'b000) && !req_onehot;
    units_start_d = '0;
    case (motor_req)
      3'b100:  units_start_d = load ? dose_r : dose_r_q;
      3'b010:  units_start_d = load ? dose_y : dose_y_q;
      3'b001:  units_start_d = load ? dose_b : dose_b_q;
      default: units_start_d = '0;
    endcase
  end

  // Sequencing FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dose_r_q   <= '0;
      dose_y_q   <= '0;
      dose_b_q   <= '0;
      ch_q       <= 3'b000;
      units_q    <= '0;
      presc_q    <= '0;
      settle_q   <= '0;
      motor_on_q <= 3'b000;
      flags_q    <= 3'b000;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load) begin
            dose_r_q <= dose_r;
            dose_y_q <= dose_y;
            dose_b_q <= dose_b;
          end
          if (req_onehot) begin
            ch_q    <= motor_req;
            units_q <= units_start_d;
            presc_q <= '0;
            busy_q  <= 1'b1;
            if (units_start_d != '0) begin
              state_q    <= S_RUN;
              motor_on_q <= motor_req;
            end else begin
              // zero dose: skip the motor entirely but still settle
              state_q  <= S_SETTLE;
              settle_q <= SETTLE_LOAD;
            end
          end else if (req_multi) begin
            err_q <= 1'b1;
          end
        end

        S_RUN: begin
          if (motor_req != ch_q) begin
            state_q    <= S_IDLE;
            motor_on_q <= 3'b000;
            busy_q     <= 1'b0;
            err_q      <= req_multi;
          end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            units_q <= units_q - UNITS_ONE;
            if (units_q == UNITS_ONE) begin
              state_q    <= S_SETTLE;
              motor_on_q <= 3'b000;
              settle_q   <= SETTLE_LOAD;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end

        S_SETTLE: begin
          if (motor_req != ch_q) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            settle_q <= '0;
            err_q    <= req_multi;
          end else if (settle_q == SETTLE_ONE) begin
            state_q  <= S_DONE;
            settle_q <= '0;
            busy_q   <= 1'b0;
            flags_q  <= ch_q;
          end else begin
            settle_q <= settle_q - SETTLE_ONE;
          end
        end

        S_DONE: begin
          if (motor_req != ch_q) begin
            state_q <= S_IDLE;
            flags_q <= 3'b000;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          motor_on_q <= 3'b000;
          flags_q    <= 3'b000;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign motor_on = motor_on_q;
  assign flags    = flags_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_motor_dose_timer.sv
// Bench for motor_dose_timer with TICKS_PER_UNIT=4, SETTLE_CYCLES=2.
// Stimulus pushes expected output episodes (motor pulse, flag, abort, err)
// into a queue; a negedge monitor measures the episodes the DUT produces and
// compares them against the queue in order.
module tb_motor_dose_timer;

  localparam int T = 4;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset, load;
  logic [7:0] dose_r, dose_y, dose_b;
  logic [2:0] motor_req, motor_on, flags;
  logic       busy, err;

  always #5 clk = ~clk;

  motor_dose_timer #(.DOSE_W(8), .TICKS_PER_UNIT(T), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .load(load),
    .dose_r(dose_r), .dose_y(dose_y), .dose_b(dose_b),
    .motor_req(motor_req), .motor_on(motor_on), .flags(flags),
    .busy(busy), .err(err)
  );

  typedef enum int {EV_RUN, EV_FLAG, EV_ABORT, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [2:0] val;
    int         len;
  } ev_t;

  ev_t sb[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(ev_kind_t k, logic [2:0] v, int len);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.len  = len;
    sb.push_back(e);
  endtask

  task automatic observe(ev_kind_t k, logic [2:0] v, int len);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s val=%b len=%0d, expected none",
               k.name(), v, len);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val !== v || e.len != len) begin
        n_fail++;
        $display("FAIL event: got %s val=%b len=%0d, expected %s val=%b len=%0d",
                 k.name(), v, len, e.kind.name(), e.val, e.len);
      end
    end
  endtask

  // Monitor: measure motor pulses, busy episodes and err pulses.
  int         run_len  = 0;
  int         busy_len = 0;
  int         err_len  = 0;
  logic [2:0] run_val  = 3'b000;

  always @(negedge clk) begin
    if (motor_on != 3'b000) begin
      run_len++;
      run_val = motor_on;
    end else if (run_len != 0) begin
      observe(EV_RUN, run_val, run_len);
      run_len = 0;
    end
    if (busy) begin
      busy_len++;
    end else if (busy_len != 0) begin
      observe((flags != 3'b000) ? EV_FLAG : EV_ABORT, flags, busy_len);
      busy_len = 0;
    end
    if (err) begin
      err_len++;
    end else if (err_len != 0) begin
      observe(EV_ERR, 3'b000, err_len);
      err_len = 0;
    end
    check("motor_on_at_most_one", int'($countones(motor_on) <= 1), 1);
    check("flags_at_most_one", int'($countones(flags) <= 1), 1);
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_flag(string name);
    int n = 0;
    while (flags == 3'b000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(flags != 3'b000), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load = 1'b0; motor_req = 3'b000;
    dose_r = 8'd0; dose_y = 8'd0; dose_b = 8'd0;
    tick(3);
    check("reset_motor_on", int'(motor_on), 0);
    check("reset_flags", int'(flags), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_err", int'(err), 0);
    reset = 1'b0;
    tick(1);

    // 1/2: load r=3,y=1,b=2 then R -> Y -> B sequence
    load = 1'b1; dose_r = 8'd3; dose_y = 8'd1; dose_b = 8'd2;
    tick(1);
    load = 1'b0;
    expect_ev(EV_RUN, 3'b100, 3*T);
    expect_ev(EV_FLAG, 3'b100, 3*T + S);
    motor_req = 3'b100;
    wait_flag("flag_r_timeout");
    tick(2);
    check("flag_r_held", int'(flags), 4);
    expect_ev(EV_RUN, 3'b010, 1*T);
    expect_ev(EV_FLAG, 3'b010, 1*T + S);
    motor_req = 3'b010;
    tick(1);
    check("flag_r_clear_1edge", int'(flags), 0);
    wait_flag("flag_y_timeout");
    expect_ev(EV_RUN, 3'b001, 2*T);
    expect_ev(EV_FLAG, 3'b001, 2*T + S);
    motor_req = 3'b001;
    tick(1);
    check("flag_y_clear_1edge", int'(flags), 0);
    wait_flag("flag_b_timeout");
    motor_req = 3'b000;
    tick(1);
    check("flag_b_clear_1edge", int'(flags), 0);
    check("idle_busy", int'(busy), 0);
    tick(2);

    // 3: load y=0 in the same cycle as the Y request -> settle-only path
    load = 1'b1; dose_r = 8'd3; dose_y = 8'd0; dose_b = 8'd2;
    expect_ev(EV_FLAG, 3'b010, S);
    motor_req = 3'b010;
    tick(1);
    load = 1'b0;
    wait_flag("flag_zero_dose_timeout");
    motor_req = 3'b000;
    tick(2);

    // 4: drop R request during the 5th RUN cycle
    expect_ev(EV_RUN, 3'b100, 5);
    expect_ev(EV_ABORT, 3'b000, 5);
    motor_req = 3'b100;
    tick(5);
    motor_req = 3'b000;
    tick(1);
    check("abort_motor_off", int'(motor_on), 0);
    check("abort_busy", int'(busy), 0);
    tick(3);
    check("abort_no_flag", int'(flags), 0);

    // 5: multi-hot request in IDLE, then load during RUN
    expect_ev(EV_ERR, 3'b000, 1);
    motor_req = 3'b110;
    tick(1);
    motor_req = 3'b000;
    check("multihot_err", int'(err), 1);
    check("multihot_motor_off", int'(motor_on), 0);
    tick(2);
    load = 1'b1; dose_r = 8'd2;
    tick(1);
    load = 1'b0;
    expect_ev(EV_RUN, 3'b100, 2*T);
    expect_ev(EV_FLAG, 3'b100, 2*T + S);
    motor_req = 3'b100;
    tick(2);
    load = 1'b1; dose_r = 8'd7;
    tick(1);
    load = 1'b0;
    wait_flag("flag_load_in_run_timeout");
    motor_req = 3'b000;
    tick(2);

    // multi-hot abort during RUN of B (dose 2)
    expect_ev(EV_RUN, 3'b001, 2);
    expect_ev(EV_ABORT, 3'b000, 2);
    expect_ev(EV_ERR, 3'b000, 1);
    motor_req = 3'b001;
    tick(2);
    motor_req = 3'b011;
    tick(1);
    motor_req = 3'b000;
    check("multihot_abort_busy", int'(busy), 0);
    check("multihot_abort_err", int'(err), 1);
    tick(3);

    // 6: reset mid-RUN, then request with cleared doses
    expect_ev(EV_RUN, 3'b100, 3);
    expect_ev(EV_ABORT, 3'b000, 3);
    motor_req = 3'b100;
    tick(3);
    reset = 1'b1;
    motor_req = 3'b000;
    tick(1);
    check("midrun_reset_motor_on", int'(motor_on), 0);
    check("midrun_reset_busy", int'(busy), 0);
    check("midrun_reset_flags", int'(flags), 0);
    reset = 1'b0;
    tick(1);
    expect_ev(EV_FLAG, 3'b100, S);
    motor_req = 3'b100;
    wait_flag("flag_after_reset_timeout");
    motor_req = 3'b000;
    tick(3);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
